traffic_light_monitor: RTL and testbench

Passive checker that sits on the light outputs of the traffic controller. It decodes the horizontal/vertical light pair each cycle and tracks which controller phase is active, including which of the two yellow phases it is. It measures how long each phase lasts, counts completed signal cycles, and raises a sticky fault on any illegal light combination, illegal phase sequence, or timing violation. It shares the controller's clock and drives fault and status signals to the supervisory logic.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/light_pair_decoder.sv | 25 ++
 rtl/traffic_light_monitor.sv | 196 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic controller and its monitor.
//   - light codes driven on horizontal_light / vertical_light
//   - 2-bit phase encoding (shared with the controller's own state)
//   - decoded light-pair classes produced by light_pair_decoder
//   - monitor fault codes and the monitor FSM state enum
package traffic_pkg;

    // Light codes. 2'b01 is never driven by a healthy controller.
    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    // Controller phase encoding.
    localparam logic [1:0] PH_RG = 2'b00;  // horizontal red, vertical green
    localparam logic [1:0] PH_Y1 = 2'b01;  // yellow after RG
    localparam logic [1:0] PH_GR = 2'b10;  // horizontal green, vertical red
    localparam logic [1:0] PH_Y2 = 2'b11;  // yellow after GR

    // Decoded light-pair classes.
    localparam logic [1:0] PAIR_RG      = 2'd0;
    localparam logic [1:0] PAIR_YY      = 2'd1;
    localparam logic [1:0] PAIR_GR      = 2'd2;
    localparam logic [1:0] PAIR_ILLEGAL = 2'd3;

    // Fault codes.
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ILLEGAL_PAIR = 3'd1;
    localparam logic [2:0] FC_ILLEGAL_TRAN = 3'd2;
    localparam logic [2:0] FC_GREEN_LONG   = 3'd3;
    localparam logic [2:0] FC_YELLOW_LONG  = 3'd4;
    localparam logic [2:0] FC_YELLOW_SHORT = 3'd5;

    // Monitor FSM states.
    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_RG    = 3'd1,
        ST_Y1    = 3'd2,
        ST_GR    = 3'd3,
        ST_Y2    = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

endpackage

// File: rtl/light_pair_decoder.sv
// light_pair_decoder: classifies a horizontal/vertical light pair.
// Ports:
//   horizontal_light [1:0] - horizontal light code
//   vertical_light   [1:0] - vertical light code
//   pair             [1:0] - PAIR_RG, PAIR_YY, PAIR_GR or PAIR_ILLEGAL
// Purely combinational.
module light_pair_decoder
    import traffic_pkg::*;
(
    input  logic [1:0] horizontal_light,
    input  logic [1:0] vertical_light,
    output logic [1:0] pair
);

    always_comb begin
        pair = PAIR_ILLEGAL;
        if (horizontal_light == LIGHT_RED && vertical_light == LIGHT_GREEN)
            pair = PAIR_RG;
        else if (horizontal_light == LIGHT_YELLOW && vertical_light == LIGHT_YELLOW)
            pair = PAIR_YY;
        else if (horizontal_light == LIGHT_GREEN && vertical_light == LIGHT_RED)
            pair = PAIR_GR;
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the traffic controller's lights.
// Tracks the controller phase, measures dwell per phase, counts completed
// signal cycles and latches a sticky fault on illegal pairs, illegal phase
// sequences or timing violations.
// Ports:
//   clk, reset        - clock; synchronous active-low reset
//   horizontal_light  - horizontal light code (sampled every edge)
//   vertical_light    - vertical light code
//   clear_fault       - releases a latched fault (only acted on in FAULT)
//   phase             - tracked phase (PH_*), 0 when not tracking
//   phase_valid       - phase is meaningful
//   phase_change      - one-cycle pulse on the first cycle of a new phase
//   dwell             - cycles in current phase minus 1, saturating
//   cycle_count       - completed Y2->RG transitions, wraps
//   fault, fault_code - sticky fault flag and its cause
// Output qualification: phase and phase_change carry information only while
// phase_valid is high; there is no back-pressure, every output is a registered
// per-cycle status.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MAX_GREEN  = 64,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_YELLOW = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       horizontal_light,
    input  logic [1:0]       vertical_light,
    input  logic             clear_fault,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             phase_change,
    output logic [CNT_W-1:0] dwell,
    output logic [15:0]      cycle_count,
    output logic             fault,
    output logic [2:0]       fault_code
);

    logic [1:0] pair;

    light_pair_decoder u_decoder (
        .horizontal_light (horizontal_light),
        .vertical_light   (vertical_light),
        .pair             (pair)
    );

    state_t           state_q, state_d;
    logic [1:0]       phase_d;
    logic             phase_valid_d, phase_change_d;
    logic [CNT_W-1:0] dwell_d;
    logic [15:0]      cycle_count_d;
    logic             fault_d;
    logic [2:0]       fault_code_d;

    // Per-state view of what "stay" and "advance" look like.
    logic [1:0] stay_pair, next_pair, next_phase;
    state_t     next_st;
    logic       is_yellow;
    int         limit;
    logic       hit;
    logic [2:0] hit_code;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            phase        <= PH_RG;
            phase_valid  <= 1'b0;
            phase_change <= 1'b0;
            dwell        <= '0;
            cycle_count  <= '0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
        end else begin
            state_q      <= state_d;
            phase        <= phase_d;
            phase_valid  <= phase_valid_d;
            phase_change <= phase_change_d;
            dwell        <= dwell_d;
            cycle_count  <= cycle_count_d;
            fault        <= fault_d;
            fault_code   <= fault_code_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase;
        phase_valid_d  = phase_valid;
        phase_change_d = 1'b0;
        dwell_d        = dwell;
        cycle_count_d  = cycle_count;
        fault_d        = fault;
        fault_code_d   = fault_code;
        hit            = 1'b0;
        hit_code       = FC_NONE;

        stay_pair  = PAIR_RG;
        next_pair  = PAIR_YY;
        next_st    = ST_Y1;
        next_phase = PH_Y1;
        is_yellow  = 1'b0;
        case (state_q)
            ST_Y1: begin
                stay_pair  = PAIR_YY;
                next_pair  = PAIR_GR;
                next_st    = ST_GR;
                next_phase = PH_GR;
                is_yellow  = 1'b1;
            end
            ST_GR: begin
                stay_pair  = PAIR_GR;
                next_pair  = PAIR_YY;
                next_st    = ST_Y2;
                next_phase = PH_Y2;
            end
            ST_Y2: begin
                stay_pair  = PAIR_YY;
                next_pair  = PAIR_RG;
                next_st    = ST_RG;
                next_phase = PH_RG;
                is_yellow  = 1'b1;
            end
            default: ;
        endcase
        limit = is_yellow ? MAX_YELLOW : MAX_GREEN;

        case (state_q)
            ST_SYNC: begin
                phase_d       = PH_RG;
                phase_valid_d = 1'b0;
                dwell_d       = '0;
                // YY alone cannot tell Y1 from Y2, so stay until a green shows.
                if (pair == PAIR_ILLEGAL) begin
                    hit      = 1'b1;
                    hit_code = FC_ILLEGAL_PAIR;
                end else if (pair == PAIR_RG || pair == PAIR_GR) begin
                    state_d        = (pair == PAIR_RG) ? ST_RG : ST_GR;
                    phase_d        = (pair == PAIR_RG) ? PH_RG : PH_GR;
                    phase_valid_d  = 1'b1;
                    phase_change_d = 1'b1;
                end
            end
            ST_RG, ST_Y1, ST_GR, ST_Y2: begin
                if (pair == PAIR_ILLEGAL) begin
                    hit      = 1'b1;
                    hit_code = FC_ILLEGAL_PAIR;
                end else if (pair == stay_pair) begin
                    // dwell+1 samples so far; this one would be sample dwell+2.
                    if (limit != 0 && int'(dwell) + 1 >= limit) begin
                        hit      = 1'b1;
                        hit_code = is_yellow ? FC_YELLOW_LONG : FC_GREEN_LONG;
                    end else if (dwell != '1) begin
                        dwell_d = dwell + 1'b1;
                    end
                end else if (pair == next_pair) begin
                    if (is_yellow && int'(dwell) + 1 < MIN_YELLOW) begin
                        hit      = 1'b1;
                        hit_code = FC_YELLOW_SHORT;
                    end else begin
                        state_d        = next_st;
                        phase_d        = next_phase;
                        phase_change_d = 1'b1;
                        dwell_d        = '0;
                        if (state_q == ST_Y2)
                            cycle_count_d = cycle_count + 16'd1;
                    end
                end else begin
                    hit      = 1'b1;
                    hit_code = FC_ILLEGAL_TRAN;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d      = ST_SYNC;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                    dwell_d      = '0;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // Dwell is left frozen at its last value while faulted.
        if (hit) begin
            state_d        = ST_FAULT;
            fault_d        = 1'b1;
            fault_code_d   = hit_code;
            phase_d        = PH_RG;
            phase_valid_d  = 1'b0;
            phase_change_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios followed by a randomized
// controller with injected glitches, clears and resets. A reference model
// tracks phase index and run length; expected outputs go into a queue and a
// negedge monitor pops and compares.
module tb_traffic_light_monitor;

  localparam int MAX_GREEN  = 12;
  localparam int MIN_YELLOW = 2;
  localparam int MAX_YELLOW = 4;
  localparam int CNT_W      = 4;
  // {dwell_care, phase, phase_valid, phase_change, dwell, cycle_count, fault, code}
  localparam int W = 28;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] G = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       horizontal_light = 2'b00;
  logic [1:0]       vertical_light = 2'b00;
  logic             clear_fault = 1'b0;
  logic [1:0]       phase;
  logic             phase_valid;
  logic             phase_change;
  logic [CNT_W-1:0] dwell;
  logic [15:0]      cycle_count;
  logic             fault;
  logic [2:0]       fault_code;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MAX_GREEN  (MAX_GREEN),
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_YELLOW (MAX_YELLOW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .horizontal_light (horizontal_light),
    .vertical_light   (vertical_light),
    .clear_fault      (clear_fault),
    .phase            (phase),
    .phase_valid      (phase_valid),
    .phase_change     (phase_change),
    .dwell            (dwell),
    .cycle_count      (cycle_count),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: phase index 0..3 in controller order, run = samples in it.
  bit         m_track = 0;
  bit         m_fault = 0;
  int         m_idx = 0;
  int         m_run = 0;
  logic [2:0] m_code = 3'd0;
  logic [15:0] m_cc = 16'd0;

  // 0 = RG pair, 1 = both yellow, 2 = GR pair, -1 = anything else
  function automatic int classify(input logic [1:0] h, input logic [1:0] v);
    if (h == R && v == G) return 0;
    if (h == Y && v == Y) return 1;
    if (h == G && v == R) return 2;
    return -1;
  endfunction

  function automatic int pair_class_of_phase(input int idx);
    return (idx == 3) ? 1 : idx;
  endfunction

  function automatic logic [3:0] lights_of_phase(input int idx);
    case (idx)
      0: return {R, G};
      2: return {G, R};
      default: return {Y, Y};
    endcase
  endfunction

  task automatic flag(input logic [2:0] c);
    m_fault = 1;
    m_code  = c;
    m_track = 0;
  endtask

  task automatic drive(input logic [1:0] h, input logic [1:0] v, input logic clr, input logic rst_n);
    int k;
    int lim;
    int d;
    logic pc;
    logic [1:0] ph;
    logic [3:0] d4;
    horizontal_light = h;
    vertical_light   = v;
    clear_fault      = clr;
    reset            = rst_n;
    pc = 1'b0;
    if (!rst_n) begin
      m_track = 0; m_fault = 0; m_code = 3'd0; m_cc = 16'd0; m_run = 0; m_idx = 0;
    end else if (m_fault) begin
      if (clr) begin
        m_fault = 0; m_code = 3'd0; m_track = 0; m_run = 0;
      end
    end else begin
      k = classify(h, v);
      if (k < 0) flag(3'd1);
      else if (!m_track) begin
        if (k != 1) begin
          m_track = 1; m_idx = k; m_run = 1; pc = 1'b1;
        end
      end else if (k == pair_class_of_phase(m_idx)) begin
        m_run++;
        lim = (m_idx % 2 == 0) ? MAX_GREEN : MAX_YELLOW;
        if (lim != 0 && m_run > lim) flag((m_idx % 2 == 0) ? 3'd3 : 3'd4);
      end else if (k == pair_class_of_phase((m_idx + 1) % 4)) begin
        if (m_idx % 2 == 1 && m_run < MIN_YELLOW) flag(3'd5);
        else begin
          if (m_idx == 3) m_cc++;
          m_idx = (m_idx + 1) % 4;
          m_run = 1;
          pc = 1'b1;
        end
      end else flag(3'd2);
    end
    d  = m_track ? ((m_run - 1 > 15) ? 15 : m_run - 1) : 0;
    d4 = 4'(d);
    ph = m_track ? 2'(m_idx) : 2'b00;
    exp_q.push_back({~m_fault, ph, m_track, pc, d4, m_cc, m_fault, m_code});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold(input logic [1:0] h, input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) drive(h, v, 1'b0, 1'b1);
  endtask

  // Monitor: outputs of each edge are checked at the following negedge.
  logic [W:0]   mon_e;
  logic [W-1:0] mon_x, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_x = mon_e[W-1:0];
      mon_a = {phase, phase_valid, phase_change, dwell, cycle_count, fault, fault_code};
      if (!mon_e[W]) begin
        mon_x[23:20] = 4'd0;
        mon_a[23:20] = 4'd0;
      end
      n_cmp++;
      if (mon_a !== mon_x) begin
        n_bad++;
        $display("FAIL outputs @cycle %0d: actual ph=%0d pv=%0d pc=%0d dw=%0d cc=%0d f=%0d code=%0d, required ph=%0d pv=%0d pc=%0d dw=%0d cc=%0d f=%0d code=%0d",
                 cyc, mon_a[27:26], mon_a[25], mon_a[24], mon_a[23:20], mon_a[19:4], mon_a[3], mon_a[2:0],
                 mon_x[27:26], mon_x[25], mon_x[24], mon_x[23:20], mon_x[19:4], mon_x[3], mon_x[2:0]);
      end
    end
  end

  initial begin
    int ci;
    int left;
    logic [3:0] p;
    logic clr;
    logic rn;

    // reset
    drive(R, G, 1'b0, 1'b0);
    drive(R, G, 1'b0, 1'b0);
    // sync on RG, dwell counts
    hold(R, G, 2);
    // full cycle with 2-cycle yellows, cycle_count increments on Y2->RG
    hold(Y, Y, 2); hold(G, R, 3); hold(Y, Y, 2); hold(R, G, 1);
    // one-cycle yellow is too short
    hold(Y, Y, 1); hold(G, R, 1); hold(G, R, 3);
    drive(G, R, 1'b1, 1'b1);
    hold(G, R, 2);
    // illegal pair, hold, clear, resync on GR
    hold(G, G, 1); hold(G, G, 3);
    drive(R, G, 1'b1, 1'b1);
    hold(Y, Y, 1); hold(G, R, 1);
    // 01 code on one light
    hold(2'b01, R, 1);
    drive(R, G, 1'b1, 1'b1);
    // RG straight to GR
    hold(R, G, 2); hold(G, R, 1);
    drive(G, R, 1'b1, 1'b1);
    // green overstay
    hold(G, R, MAX_GREEN + 1);
    drive(R, G, 1'b1, 1'b1);
    // yellow overstay
    hold(R, G, 1); hold(Y, Y, MAX_YELLOW + 1);
    drive(R, G, 1'b1, 1'b1);
    // clear outside FAULT is ignored
    hold(R, G, 1);
    drive(R, G, 1'b1, 1'b1);
    // reset mid-Y1, then YY alone does not resync
    hold(Y, Y, 1);
    drive(Y, Y, 1'b0, 1'b0);
    hold(Y, Y, 3); hold(G, R, 2);

    // randomized controller with glitches, clears and resets
    ci = 2;
    left = 3;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        ci = (ci + 1) % 4;
        left = (ci % 2 == 0) ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 5));
      end
      p = lights_of_phase(ci);
      if ($urandom_range(0, 39) == 0) p = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 5) == 0);
      rn  = ($urandom_range(0, 249) != 0);
      drive(p[3:2], p[1:0], clr, rn);
      left--;
    end

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
